i2c_adc_target: RTL and testbench

I2C_ADC_TARGET -- requirements
Module: i2c_adc_target

---
 rtl/i2c_adc_target_pkg.sv | 40 ++++
 rtl/i2c_adc_target_bus_monitor.sv | 51 +++++
 rtl/i2c_adc_target.sv | 243 ++++++++++++++++++++++++
 tb/tb_i2c_adc_target.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_adc_target_pkg.sv
// Shared definitions for the I2C ADC target.
// Contents:
//   state_t        - protocol FSM state encoding
//   PTR_*          - register pointer values
//   *_RESET/DEFAULT- register reset values
//   reg_reset()    - reset value lookup by pointer
package i2c_adc_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_BYTE  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_BYTE  = 3'd5,
        ST_RD_ACK   = 3'd6
    } state_t;

    localparam logic [1:0] PTR_CONV = 2'd0;
    localparam logic [1:0] PTR_CFG  = 2'd1;
    localparam logic [1:0] PTR_LO   = 2'd2;
    localparam logic [1:0] PTR_HI   = 2'd3;

    localparam logic [15:0] CONV_RESET  = 16'h0000;
    localparam logic [15:0] CFG_DEFAULT = 16'h8583;
    localparam logic [15:0] LO_RESET    = 16'h8000;
    localparam logic [15:0] HI_RESET    = 16'h7FFF;

    function automatic logic [15:0] reg_reset(input logic [1:0] ptr);
        logic [15:0] v;
        case (ptr)
            PTR_CONV: v = CONV_RESET;
            PTR_CFG:  v = CFG_DEFAULT;
            PTR_LO:   v = LO_RESET;
            default:  v = HI_RESET;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/i2c_adc_target_bus_monitor.sv
// i2c_bus_monitor: synchronizes SCL/SDA into clk and flags bus events.
// Ports:
//   i_clk, i_rst_n   - system clock, async active-low reset
//   i_scl, i_sda     - raw bus lines (asynchronous)
//   o_sda            - synchronized SDA
//   o_scl_rise/fall  - one-cycle SCL edge strobes
//   o_start/o_stop   - one-cycle START / STOP strobes
module i2c_bus_monitor (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_d;
    logic       r_sda_d;
    logic       w_scl;
    logic       w_sda;

    // Reset to the idle-bus level so no spurious edge appears after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
            r_scl_d    <= r_scl_sync[1];
            r_sda_d    <= r_sda_sync[1];
        end
    end

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_d;
    assign o_scl_fall = ~w_scl & r_scl_d;
    // SCL must be high on both samples so an SCL edge is never mistaken for START/STOP.
    assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_adc_target.sv
// i2c_adc_target: I2C target exposing an ADC-style register file.
//   pointer 0 conversion (RO), 1 config, 2 Lo_thresh, 3 Hi_thresh.
// Build option: ADC_THRESH_REGS_EN - when defined, pointers 2/3 are
//   read/write threshold registers; otherwise they read 0 and ignore writes.
// Ports:
//   clk, rst_n            - system clock, async active-low reset
//   scl_i, sda_i          - bus lines (asynchronous)
//   sda_oe                - 1 pulls SDA low
//   conv_data, conv_valid - new conversion result + strobe
//   cfg_reg               - current config register (bit 15 reads 1)
//   start_conv            - pulse after committed config write with OS set
//   busy                  - high between START and STOP
//
// state       | meaning
// ST_IDLE     | ignore bus until START
// ST_ADDR     | shifting in address + R/W
// ST_ADDR_ACK | driving address ACK
// ST_WR_BYTE  | shifting in a write byte
// ST_WR_ACK   | driving write-byte ACK
// ST_RD_BYTE  | shifting out a read byte
// ST_RD_ACK   | sampling master ACK/NACK
module i2c_adc_target
    import i2c_adc_target_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = 7'b1001000,
    parameter logic [15:0] CFG_RESET = CFG_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [15:0] conv_data,
    input  logic        conv_valid,
    output logic [15:0] cfg_reg,
    output logic        start_conv,
    output logic        busy
);

    logic        w_sda;
    logic        w_scl_rise;
    logic        w_scl_fall;
    logic        w_start;
    logic        w_stop;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_bit_cnt;
    logic        r_byte_done;
    logic [7:0]  r_shift;
    logic        r_rw;
    logic        r_nack;
    logic [1:0]  r_widx;
    logic [1:0]  r_ptr;
    logic [7:0]  r_wr_msb;
    logic [15:0] r_tx;
    logic        r_rd_lsb;
    logic [15:0] r_conv;
    logic [15:0] r_cfg;
    logic        r_sda_oe;
    logic        r_busy;
    logic        r_os_pend;
    logic        r_start_conv;
    logic        w_addr_match;
    logic        w_oe_fall;
    logic [15:0] w_rd_val;
    logic [7:0]  w_tx_byte;
    logic        w_next_first;
`ifdef ADC_THRESH_REGS_EN
    logic [15:0] r_lo;
    logic [15:0] r_hi;
`endif

    i2c_bus_monitor u_bus (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_scl      (scl_i),
        .i_sda      (sda_i),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_addr_match = (r_shift[7:1] == DEV_ADDR);
    assign w_tx_byte    = r_rd_lsb ? r_tx[7:0] : r_tx[15:8];
    assign w_next_first = r_rd_lsb ? r_tx[15] : r_tx[7];

    always_comb begin
        w_rd_val = 16'h0000;
        case (r_ptr)
            PTR_CONV: w_rd_val = r_conv;
            PTR_CFG:  w_rd_val = r_cfg;
`ifdef ADC_THRESH_REGS_EN
            PTR_LO:   w_rd_val = r_lo;
            PTR_HI:   w_rd_val = r_hi;
`else
            PTR_LO, PTR_HI: w_rd_val = 16'h0000;
`endif
            default:  w_rd_val = 16'h0000;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM: next state. STOP dominates, START restarts from any state.
    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = ST_IDLE;
        end else if (w_start) begin
            w_state_nxt = ST_ADDR;
        end else if (w_scl_fall) begin
            case (r_state)
                ST_ADDR:     if (r_byte_done) w_state_nxt = w_addr_match ? ST_ADDR_ACK : ST_IDLE;
                ST_ADDR_ACK: w_state_nxt = r_rw ? ST_RD_BYTE : ST_WR_BYTE;
                ST_WR_BYTE:  if (r_byte_done) w_state_nxt = ST_WR_ACK;
                ST_WR_ACK:   w_state_nxt = ST_WR_BYTE;
                ST_RD_BYTE:  if (r_byte_done) w_state_nxt = ST_RD_ACK;
                ST_RD_ACK:   w_state_nxt = r_nack ? ST_IDLE : ST_RD_BYTE;
                default:     w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM: SDA drive value to load at an SCL falling edge.
    always_comb begin
        w_oe_fall = 1'b0;
        case (w_state_nxt)
            ST_ADDR_ACK, ST_WR_ACK: w_oe_fall = 1'b1;
            ST_RD_BYTE: begin
                case (r_state)
                    ST_ADDR_ACK: w_oe_fall = ~r_tx[15];
                    ST_RD_ACK:   w_oe_fall = ~w_next_first;
                    default:     w_oe_fall = ~w_tx_byte[r_bit_cnt];
                endcase
            end
            default: w_oe_fall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= 3'd7;
            r_byte_done  <= 1'b0;
            r_shift      <= 8'h00;
            r_rw         <= 1'b0;
            r_nack       <= 1'b0;
            r_widx       <= 2'd0;
            r_ptr        <= PTR_CONV;
            r_wr_msb     <= 8'h00;
            r_tx         <= 16'h0000;
            r_rd_lsb     <= 1'b0;
            r_conv       <= reg_reset(PTR_CONV);
            r_cfg        <= CFG_RESET | 16'h8000;
            r_sda_oe     <= 1'b0;
            r_busy       <= 1'b0;
            r_os_pend    <= 1'b0;
            r_start_conv <= 1'b0;
`ifdef ADC_THRESH_REGS_EN
            r_lo         <= reg_reset(PTR_LO);
            r_hi         <= reg_reset(PTR_HI);
`endif
        end else begin
            r_os_pend    <= 1'b0;
            r_start_conv <= r_os_pend;
            if (conv_valid) r_conv <= conv_data;

            if (w_stop) begin
                r_busy      <= 1'b0;
                r_sda_oe    <= 1'b0;
                r_byte_done <= 1'b0;
            end else if (w_start) begin
                r_busy      <= 1'b1;
                r_sda_oe    <= 1'b0;
                r_bit_cnt   <= 3'd7;
                r_byte_done <= 1'b0;
            end else begin
                if (w_scl_rise) begin
                    case (r_state)
                        ST_ADDR, ST_WR_BYTE, ST_RD_BYTE: begin
                            if (r_state != ST_RD_BYTE) r_shift <= {r_shift[6:0], w_sda};
                            if (r_bit_cnt == 3'd0) r_byte_done <= 1'b1;
                            else                   r_bit_cnt   <= r_bit_cnt - 3'd1;
                        end
                        ST_RD_ACK: r_nack <= w_sda;
                        default: ;
                    endcase
                end
                if (w_scl_fall) begin
                    r_sda_oe    <= w_oe_fall;
                    r_byte_done <= 1'b0;
                    if (w_state_nxt != r_state) r_bit_cnt <= 3'd7;
                    case (r_state)
                        ST_ADDR: if (r_byte_done) begin
                            r_rw     <= r_shift[0];
                            r_widx   <= 2'd0;
                            r_rd_lsb <= 1'b0;
                            // Snapshot now so a conversion landing mid-read cannot tear the value.
                            if (w_addr_match && r_shift[0]) r_tx <= w_rd_val;
                        end
                        ST_WR_BYTE: if (r_byte_done) begin
                            if (r_widx != 2'd3) r_widx <= r_widx + 2'd1;
                            case (r_widx)
                                2'd0: r_ptr    <= r_shift[1:0];
                                2'd1: r_wr_msb <= r_shift;
                                2'd2: begin
                                    case (r_ptr)
                                        PTR_CFG: begin
                                            r_cfg     <= {1'b1, r_wr_msb[6:0], r_shift};
                                            r_os_pend <= r_wr_msb[7];
                                        end
`ifdef ADC_THRESH_REGS_EN
                                        PTR_LO: r_lo <= {r_wr_msb, r_shift};
                                        PTR_HI: r_hi <= {r_wr_msb, r_shift};
`else
                                        PTR_LO, PTR_HI: ;
`endif
                                        default: ;
                                    endcase
                                end
                                default: ;
                            endcase
                        end
                        ST_RD_ACK: if (!r_nack) r_rd_lsb <= ~r_rd_lsb;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign sda_oe     = r_sda_oe;
    assign cfg_reg    = r_cfg;
    assign start_conv = r_start_conv;
    assign busy       = r_busy;

endmodule

// File: tb/tb_i2c_adc_target.sv
module tb_i2c_adc_target;

    localparam int Q = 10;
`ifdef ADC_THRESH_REGS_EN
    localparam bit THRESH_EN = 1'b1;
`else
    localparam bit THRESH_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        scl_m;
    logic        sda_m;
    logic        sda_line;
    logic        sda_oe;
    logic [15:0] conv_data;
    logic        conv_valid;
    logic [15:0] cfg_reg;
    logic        start_conv;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          sc_cnt = 0;

    string       exp_name_q[$];
    logic [15:0] exp_val_q[$];
    logic [15:0] obs_q[$];

    assign sda_line = sda_m & ~sda_oe;

    i2c_adc_target dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (scl_m),
        .sda_i      (sda_line),
        .sda_oe     (sda_oe),
        .conv_data  (conv_data),
        .conv_valid (conv_valid),
        .cfg_reg    (cfg_reg),
        .start_conv (start_conv),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (start_conv === 1'b1) sc_cnt <= sc_cnt + 1;

    // Monitor: pairs each observed response with the oldest expectation.
    initial begin
        logic [15:0] ov;
        logic [15:0] ev;
        string       en;
        forever begin
            @(negedge clk);
            while (obs_q.size() != 0) begin
                ov = obs_q.pop_front();
                checks++;
                if (exp_val_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_obs got=%h", ov);
                end else begin
                    ev = exp_val_q.pop_front();
                    en = exp_name_q.pop_front();
                    if (ov !== ev) begin
                        errors++;
                        $display("FAIL %s got=%h exp=%h", en, ov, ev);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog timeout pending_exp=%0d", exp_val_q.size());
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string name, input logic [15:0] v);
        exp_name_q.push_back(name);
        exp_val_q.push_back(v);
    endtask

    task automatic observe(input logic [15:0] v);
        obs_q.push_back(v);
    endtask

    task automatic conv_load(input logic [15:0] v);
        conv_data  = v;
        conv_valid = 1'b1;
        tick(1);
        conv_valid = 1'b0;
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2 * Q);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(Q);
        s = sda_line; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    // exp_line is the SDA level on the 9th clock: 0 = ACK, 1 = no ACK.
    task automatic write_byte(input logic [7:0] b, input logic exp_line, input string name);
        logic s;
        expect_v(name, {15'h0, exp_line});
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        observe({15'h0, s});
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic mack, input logic inject,
                             input logic [15:0] inj_val, input string name);
        logic       s;
        logic [7:0] d;
        expect_v(name, {8'h00, exp});
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
            if (inject && i == 5) conv_load(inj_val);
        end
        clock_bit(~mack, s);
        observe({8'h00, d});
    endtask

    task automatic set_ptr(input logic [7:0] p, input string tag);
        i2c_start;
        write_byte(8'h90, 1'b0, {tag, "_addr_ack"});
        write_byte(p,     1'b0, {tag, "_ptr_ack"});
        i2c_stop;
    endtask

    task automatic wr_reg(input logic [7:0] p, input logic [15:0] v, input string tag);
        i2c_start;
        write_byte(8'h90,   1'b0, {tag, "_addr_ack"});
        write_byte(p,       1'b0, {tag, "_ptr_ack"});
        write_byte(v[15:8], 1'b0, {tag, "_msb_ack"});
        write_byte(v[7:0],  1'b0, {tag, "_lsb_ack"});
        i2c_stop;
    endtask

    task automatic rd2(input logic [15:0] exp, input string tag);
        i2c_start;
        write_byte(8'h91, 1'b0, {tag, "_addr_ack"});
        read_byte(exp[15:8], 1'b1, 1'b0, 16'h0, {tag, "_msb"});
        read_byte(exp[7:0],  1'b0, 1'b0, 16'h0, {tag, "_lsb"});
        expect_v({tag, "_oe_after_nack"}, 16'h0);
        observe({15'h0, sda_oe});
        i2c_stop;
    endtask

    initial begin
        logic s;
        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        conv_valid = 1'b0; conv_data = 16'h0000;
        tick(5);
        expect_v("rst_sda_oe", 16'h0);     observe({15'h0, sda_oe});
        expect_v("rst_busy", 16'h0);       observe({15'h0, busy});
        expect_v("rst_start_conv", 16'h0); observe({15'h0, start_conv});
        expect_v("rst_cfg", 16'h8583);     observe(cfg_reg);
        rst_n = 1'b1;
        tick(5);

        // Config write with OS set
        i2c_start;
        expect_v("busy_after_start", 16'h1); observe({15'h0, busy});
        write_byte(8'h90, 1'b0, "cw_addr_ack");
        write_byte(8'h01, 1'b0, "cw_ptr_ack");
        write_byte(8'hC4, 1'b0, "cw_msb_ack");
        write_byte(8'h83, 1'b0, "cw_lsb_ack");
        i2c_stop;
        expect_v("busy_after_stop", 16'h0); observe({15'h0, busy});
        expect_v("cw_cfg", 16'hC483);       observe(cfg_reg);
        expect_v("cw_start_cnt", 16'd1);    observe(16'(sc_cnt));

        // Conversion readback
        conv_load(16'h1234);
        set_ptr(8'h00, "p0");
        rd2(16'h1234, "conv_rd");

        // Address mismatch then normal transaction
        i2c_start;
        write_byte(8'h92, 1'b1, "bad_addr_nack");
        i2c_stop;
        rd2(16'h1234, "after_bad");

        // Conversion update during MSB shift
        i2c_start;
        write_byte(8'h91, 1'b0, "snap_addr_ack");
        read_byte(8'h12, 1'b1, 1'b1, 16'hABCD, "snap_msb");
        read_byte(8'h34, 1'b0, 1'b0, 16'h0, "snap_lsb");
        i2c_stop;
        rd2(16'hABCD, "new_conv");

        // Partial config write discarded
        i2c_start;
        write_byte(8'h90, 1'b0, "part_addr_ack");
        write_byte(8'h01, 1'b0, "part_ptr_ack");
        write_byte(8'h12, 1'b0, "part_msb_ack");
        i2c_stop;
        expect_v("part_cfg", 16'hC483);    observe(cfg_reg);
        expect_v("part_start_cnt", 16'd1); observe(16'(sc_cnt));
        rd2(16'hC483, "cfg_rd");

        // Reset mid-read while SDA is driven low (cfg MSB 0xC4, bit 5 = 0)
        i2c_start;
        write_byte(8'h91, 1'b0, "rst_rd_addr_ack");
        clock_bit(1'b1, s);
        clock_bit(1'b1, s);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        expect_v("oe_before_reset", 16'h1); observe({15'h0, sda_oe});
        rst_n = 1'b0;
        #1;
        expect_v("oe_async_reset", 16'h0);  observe({15'h0, sda_oe});
        tick(5);
        rst_n = 1'b1;
        tick(5);
        expect_v("post_rst_cfg", 16'h8583); observe(cfg_reg);
        expect_v("post_rst_busy", 16'h0);   observe({15'h0, busy});
        rd2(16'h0000, "post_rst_conv");

        // Conversion register is read-only
        wr_reg(8'h00, 16'h5566, "wr_conv");
        rd2(16'h0000, "conv_ro");

        // Config write without OS plus an extra byte
        i2c_start;
        write_byte(8'h90, 1'b0, "x_addr_ack");
        write_byte(8'h01, 1'b0, "x_ptr_ack");
        write_byte(8'h05, 1'b0, "x_msb_ack");
        write_byte(8'h83, 1'b0, "x_lsb_ack");
        write_byte(8'hFF, 1'b0, "x_extra_ack");
        i2c_stop;
        expect_v("x_cfg", 16'h8583);    observe(cfg_reg);
        expect_v("x_start_cnt", 16'd1); observe(16'(sc_cnt));
        rd2(16'h8583, "x_cfg_rd");

        // Threshold registers
        wr_reg(8'h03, 16'h0100, "hi_wr");
        rd2(THRESH_EN ? 16'h0100 : 16'h0000, "hi_rd");
        set_ptr(8'h02, "p2");
        rd2(THRESH_EN ? 16'h8000 : 16'h0000, "lo_rd");

        tick(5);
        if (exp_val_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL unmatched_expectations got=%0d exp=0", exp_val_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
